// File: rtl/vt_text_writer_if.sv
// Byte stream into the terminal writer and the text-RAM write port out of it.
interface vt_text_writer_if #(
   parameter int COLW = 7,
   parameter int ROWW = 5
);
   logic [7:0]      din;
   logic            dinv;
   logic            wr_en;
   logic [ROWW-1:0] wr_row;
   logic [COLW-1:0] wr_col;
   logic [7:0]      wr_data;

   modport master (output din, dinv, input wr_en, wr_row, wr_col, wr_data);
   modport slave  (input din, dinv, output wr_en, wr_row, wr_col, wr_data);
endinterface

// File: rtl/vt_text_writer.sv
// Terminal byte interpreter: printable/control/ESC-CSI decode into text-RAM writes,
// with cursor, circular scroll and an input FIFO absorbing multi-cycle clears.
module vt_text_writer #(
   parameter int COLS       = 80,
   parameter int ROWS       = 30,
   parameter int COLW       = 7,
   parameter int ROWW       = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            resetn,
   vt_text_writer_if.slave bus,
   output logic [ROWW-1:0] scroll_top,
   output logic [ROWW-1:0] cursor_row,
   output logic [COLW-1:0] cursor_col,
   output logic            busy,
   output logic            error
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [COLW-1:0] LAST_COL = COLW'(COLS-1);
   localparam logic [ROWW-1:0] LAST_ROW = ROWW'(ROWS-1);
   localparam logic [PW:0]     FULL     = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, ESC, CSI, CLRLINE, CLRSCR} state_e;

   state_e          state_q, state_d;
   logic [7:0]      fifo_q [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW:0]     cnt_q, cnt_d;
   logic [3:0]      param_q, param_d;
   logic [ROWW-1:0] row_q, row_d, scroll_q, scroll_d, clr_row_q, clr_row_d, wr_row_q, wr_row_d;
   logic [COLW-1:0] col_q, col_d, clr_col_q, clr_col_d, wr_col_q, wr_col_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            wr_en_q, wr_en_d, busy_q, busy_d, error_q, error_d;
   logic            pop, push, clearing, do_lf;
   logic [7:0]      b;
   logic [ROWW:0]   phys_sum, phys_wrap;
   logic [ROWW-1:0] phys_row;
   logic [COLW:0]   tab_col;

   // Explicit modulo-ROWS wrap of scroll_top + logical row.
   assign phys_sum  = {1'b0, scroll_q} + {1'b0, row_q};
   assign phys_wrap = phys_sum - (ROWW+1)'(ROWS);
   assign phys_row  = (phys_sum >= (ROWW+1)'(ROWS)) ? phys_wrap[ROWW-1:0] : phys_sum[ROWW-1:0];
   assign tab_col   = {1'b0, col_q | COLW'(7)} + 1'b1;

   always_comb begin
      state_d   = state_q;
      param_d   = param_q;
      row_d     = row_q;
      col_d     = col_q;
      scroll_d  = scroll_q;
      clr_row_d = clr_row_q;
      clr_col_d = clr_col_q;
      wr_en_d   = 1'b0;
      wr_row_d  = wr_row_q;
      wr_col_d  = wr_col_q;
      wr_data_d = wr_data_q;
      do_lf     = 1'b0;
      clearing  = (state_q == CLRLINE) || (state_q == CLRSCR);
      pop       = !clearing && (cnt_q != '0);
      b         = fifo_q[rd_ptr_q];

      if (pop) begin
         case (state_q)
            IDLE: begin
               if (b >= 8'h20 && b <= 8'h7E) begin
                  wr_en_d   = 1'b1;
                  wr_row_d  = phys_row;
                  wr_col_d  = col_q;
                  wr_data_d = b;
                  if (col_q < LAST_COL) col_d = col_q + 1'b1;
                  else begin
                     col_d = '0;
                     do_lf = 1'b1;
                  end
               end else begin
                  case (b)
                     8'h0D: col_d = '0;
                     8'h0A: do_lf = 1'b1;
                     8'h08: if (col_q != '0) col_d = col_q - 1'b1;
                     8'h09: col_d = (tab_col > {1'b0, LAST_COL}) ? LAST_COL : tab_col[COLW-1:0];
                     8'h1B: state_d = ESC;
                     default: ;
                  endcase
               end
            end
            ESC: begin
               state_d = (b == 8'h5B) ? CSI : IDLE;
               param_d = '0;
            end
            CSI: begin
               state_d = IDLE;
               if (b >= "0" && b <= "9") begin
                  param_d = b[3:0];
                  state_d = CSI;
               end else if (b == "H") begin
                  row_d = '0;
                  col_d = '0;
               end else if (b == "J" && param_q == 4'd2) begin
                  state_d   = CLRSCR;
                  scroll_d  = '0;
                  row_d     = '0;
                  col_d     = '0;
                  clr_row_d = '0;
                  clr_col_d = '0;
               end else if (b == "K") begin
                  state_d   = CLRLINE;
                  clr_row_d = phys_row;
                  clr_col_d = col_q;
               end
            end
            default: ;
         endcase
      end

      if (do_lf) begin
         if (row_q < LAST_ROW) row_d = row_q + 1'b1;
         else begin
            // After scrolling, the old top physical row becomes the new bottom line.
            scroll_d  = (scroll_q == LAST_ROW) ? '0 : scroll_q + 1'b1;
            clr_row_d = scroll_q;
            clr_col_d = '0;
            state_d   = CLRLINE;
         end
      end

      if (clearing) begin
         wr_en_d   = 1'b1;
         wr_row_d  = clr_row_q;
         wr_col_d  = clr_col_q;
         wr_data_d = 8'h20;
         if (clr_col_q != LAST_COL) clr_col_d = clr_col_q + 1'b1;
         else begin
            clr_col_d = '0;
            if (state_q == CLRSCR && clr_row_q != LAST_ROW) clr_row_d = clr_row_q + 1'b1;
            else state_d = IDLE;
         end
      end

      // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
      push     = bus.dinv && ((cnt_q != FULL) || pop);
      error_d  = bus.dinv && !push;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      busy_d   = (cnt_d != '0) || clearing || (state_d == CLRLINE) || (state_d == CLRSCR);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         param_q   <= '0;
         row_q     <= '0;
         col_q     <= '0;
         scroll_q  <= '0;
         clr_row_q <= '0;
         clr_col_q <= '0;
         wr_en_q   <= 1'b0;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         param_q   <= param_d;
         row_q     <= row_d;
         col_q     <= col_d;
         scroll_q  <= scroll_d;
         clr_row_q <= clr_row_d;
         clr_col_q <= clr_col_d;
         wr_en_q   <= wr_en_d;
         wr_row_q  <= wr_row_d;
         wr_col_q  <= wr_col_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         error_q   <= error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= bus.din;
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_row  = wr_row_q;
   assign bus.wr_col  = wr_col_q;
   assign bus.wr_data = wr_data_q;
   assign scroll_top  = scroll_q;
   assign cursor_row  = row_q;
   assign cursor_col  = col_q;
   assign busy        = busy_q;
   assign error       = error_q;
endmodule

// File: tb/tb_vt_text_writer.sv
// Directed bench for vt_text_writer: single-byte vector table plus clear/scroll/overflow sequences.
module tb_vt_text_writer;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [4:0] scroll_top, cursor_row;
   logic [6:0] cursor_col;
   logic       busy, error;

   vt_text_writer_if #(.COLW(7), .ROWW(5)) bus ();

   vt_text_writer #(.COLS(80), .ROWS(30), .COLW(7), .ROWW(5), .FIFO_DEPTH(8)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .scroll_top(scroll_top),
      .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [4:0] row; logic [6:0] col; logic [7:0] data;} wr_t;
   typedef struct {logic [7:0] din; bit wr; int row; int col; int data; int crow; int ccol;} vec_t;

   wr_t  wq[$];
   int   err_pulses = 0;
   int   busy_gap   = 0;
   int   checks     = 0;
   int   failures   = 0;
   vec_t vt[$];

   // Write log and pulse counters, sampled away from the rising edge.
   always @(negedge clk) begin
      if (bus.wr_en) begin
         wq.push_back({bus.wr_row, bus.wr_col, bus.wr_data});
         if (bus.wr_data == 8'h20 && !busy) busy_gap++;
      end
      if (error) err_pulses++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic send(input logic [7:0] v);
      @(negedge clk);
      bus.din  = v;
      bus.dinv = 1'b1;
      @(negedge clk);
      bus.dinv = 1'b0;
   endtask

   task automatic settle(input int maxc);
      int n = 0;
      @(negedge clk);
      @(negedge clk);
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("settle_busy", int'(busy), 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic chk_wr(input string name, input int idx, input int row, input int col, input int data);
      if (idx < wq.size()) begin
         chk({name, "_row"}, int'(wq[idx].row), row);
         chk({name, "_col"}, int'(wq[idx].col), col);
         chk({name, "_data"}, int'(wq[idx].data), data);
      end else chk({name, "_present"}, wq.size(), idx + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, e0, g0, bad;
      bus.din  = 8'h00;
      bus.dinv = 1'b0;

      //             din    wr row col data crow ccol
      vt.push_back('{8'h41, 1, 0,  0, 8'h41, 0,  1});
      vt.push_back('{8'h42, 1, 0,  1, 8'h42, 0,  2});
      vt.push_back('{8'h0D, 0, 0,  0, 0,     0,  0});
      vt.push_back('{8'h0A, 0, 0,  0, 0,     1,  0});
      vt.push_back('{8'h09, 0, 0,  0, 0,     1,  8});
      vt.push_back('{8'h09, 0, 0,  0, 0,     1, 16});
      vt.push_back('{8'h08, 0, 0,  0, 0,     1, 15});
      vt.push_back('{8'h7A, 1, 1, 15, 8'h7A, 1, 16});
      vt.push_back('{8'h07, 0, 0,  0, 0,     1, 16});
      vt.push_back('{8'h1B, 0, 0,  0, 0,     1, 16});
      vt.push_back('{8'h5B, 0, 0,  0, 0,     1, 16});
      vt.push_back('{8'h48, 0, 0,  0, 0,     0,  0});
      vt.push_back('{8'h08, 0, 0,  0, 0,     0,  0});
      vt.push_back('{8'h1B, 0, 0,  0, 0,     0,  0});
      vt.push_back('{8'h78, 0, 0,  0, 0,     0,  0});
      vt.push_back('{8'h51, 1, 0,  0, 8'h51, 0,  1});
      vt.push_back('{8'h1B, 0, 0,  0, 0,     0,  1});
      vt.push_back('{8'h5B, 0, 0,  0, 0,     0,  1});
      vt.push_back('{8'h35, 0, 0,  0, 0,     0,  1});
      vt.push_back('{8'h4A, 0, 0,  0, 0,     0,  1});
      vt.push_back('{8'h21, 1, 0,  1, 8'h21, 0,  2});
      vt.push_back('{8'h7E, 1, 0,  2, 8'h7E, 0,  3});
      vt.push_back('{8'h1F, 0, 0,  0, 0,     0,  3});

      repeat (3) @(negedge clk);
      chk("rst_wr_en", int'(bus.wr_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_scroll", int'(scroll_top), 0);
      chk("rst_crow", int'(cursor_row), 0);
      chk("rst_ccol", int'(cursor_col), 0);
      resetn = 1'b1;

      // latency: din presented in cycle t, wr_en visible in cycle t+2
      @(negedge clk);
      bus.din = 8'h40; bus.dinv = 1'b1;
      @(negedge clk);
      bus.dinv = 1'b0;
      chk("lat_t1", int'(bus.wr_en), 0);
      @(negedge clk);
      chk("lat_t2", int'(bus.wr_en), 1);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      foreach (vt[i]) begin
         base = wq.size();
         send(vt[i].din);
         settle(20);
         chk($sformatf("v%0d_nwr", i), wq.size() - base, vt[i].wr ? 1 : 0);
         if (vt[i].wr) chk_wr($sformatf("v%0d", i), base, vt[i].row, vt[i].col, vt[i].data);
         chk($sformatf("v%0d_crow", i), int'(cursor_row), vt[i].crow);
         chk($sformatf("v%0d_ccol", i), int'(cursor_col), vt[i].ccol);
      end

      // printable at last column wraps to the next row
      send(8'h1B); send(8'h5B); send(8'h48);
      repeat (5) send(8'h0A);
      repeat (10) send(8'h09);
      settle(50);
      chk("A_pre_ccol", int'(cursor_col), 79);
      base = wq.size();
      send(8'h5A);
      settle(20);
      chk("A_nwr", wq.size() - base, 1);
      chk_wr("A", base, 5, 79, 8'h5A);
      chk("A_crow", int'(cursor_row), 6);
      chk("A_ccol", int'(cursor_col), 0);

      // LF on the bottom row scrolls and clears the new bottom line
      send(8'h1B); send(8'h5B); send(8'h48);
      repeat (29) send(8'h0A);
      settle(50);
      chk("B_pre_crow", int'(cursor_row), 29);
      base = wq.size();
      g0 = busy_gap;
      send(8'h0A);
      settle(200);
      chk("B_scroll", int'(scroll_top), 1);
      chk("B_crow", int'(cursor_row), 29);
      chk("B_nwr", wq.size() - base, 80);
      bad = 0;
      if (wq.size() >= base + 80)
         for (int i = 0; i < 80; i++)
            if (wq[base+i].row != 5'd0 || int'(wq[base+i].col) != i || wq[base+i].data != 8'h20) bad++;
      chk("B_order", bad, 0);
      chk("B_busy_gap", busy_gap - g0, 0);
      base = wq.size();
      send(8'h43);
      settle(20);
      chk_wr("B_wrap", base, 0, 0, 8'h43);
      chk("B_post_ccol", int'(cursor_col), 1);

      // ESC[2J with 9 bytes pushed during the clear: one dropped
      base = wq.size();
      e0 = err_pulses;
      send(8'h1B); send(8'h5B); send(8'h32); send(8'h4A);
      for (int k = 0; k < 9; k++) send(8'h61 + 8'(k));
      chk("C_scroll", int'(scroll_top), 0);
      chk("C_crow", int'(cursor_row), 0);
      chk("C_ccol", int'(cursor_col), 0);
      chk("C_busy", int'(busy), 1);
      settle(3000);
      chk("C_err", err_pulses - e0, 1);
      chk("C_nwr", wq.size() - base, 2408);
      bad = 0;
      if (wq.size() >= base + 2408) begin
         for (int i = 0; i < 2400; i++)
            if (int'(wq[base+i].row) != i / 80 || int'(wq[base+i].col) != i % 80 || wq[base+i].data != 8'h20) bad++;
         for (int k = 0; k < 8; k++)
            if (wq[base+2400+k].row != 5'd0 || int'(wq[base+2400+k].col) != k || int'(wq[base+2400+k].data) != 8'h61 + k) bad++;
      end
      chk("C_order", bad, 0);
      chk_wr("C_last", base + 2399, 29, 79, 8'h20);
      chk("C_post_ccol", int'(cursor_col), 8);

      // TAB, BS, then ESC[K from column 7
      send(8'h1B); send(8'h5B); send(8'h48);
      send(8'h0A); send(8'h0A); send(8'h78); send(8'h79); send(8'h7A);
      settle(50);
      chk("D_pre_ccol", int'(cursor_col), 3);
      send(8'h09);
      settle(20);
      chk("D_tab", int'(cursor_col), 8);
      send(8'h08);
      settle(20);
      chk("D_bs", int'(cursor_col), 7);
      base = wq.size();
      send(8'h1B); send(8'h5B); send(8'h4B);
      settle(200);
      chk("D_nwr", wq.size() - base, 73);
      bad = 0;
      if (wq.size() >= base + 73)
         for (int i = 0; i < 73; i++)
            if (wq[base+i].row != 5'd2 || int'(wq[base+i].col) != i + 7 || wq[base+i].data != 8'h20) bad++;
      chk("D_order", bad, 0);
      chk("D_crow", int'(cursor_row), 2);
      chk("D_ccol", int'(cursor_col), 7);

      // reset in the middle of a line clear
      send(8'h1B); send(8'h5B); send(8'h4B);
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("E_wr_en", int'(bus.wr_en), 0);
      chk("E_busy", int'(busy), 0);
      chk("E_crow", int'(cursor_row), 0);
      chk("E_ccol", int'(cursor_col), 0);
      @(negedge clk);
      resetn = 1'b1;
      base = wq.size();
      send(8'h41);
      settle(20);
      chk("E_nwr", wq.size() - base, 1);
      chk_wr("E", base, 0, 0, 8'h41);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vt_text_writer.md
Name: vt_text_writer

Overview:
- Downstream consumer of the arbitrated byte stream (`od`/`odv`) from the UART/keyboard data mux.
- Interprets each byte as terminal output: printable characters, control codes and a small ESC/CSI subset.
- Drives write strobes into the VGA text-buffer RAM.
- Maintains cursor position and a circular scroll offset for the display scanner.
- Multi-cycle clear operations are absorbed by an internal input FIFO, because the upstream stream has no backpressure.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, text rows
- COLW, 7, column index width (2^COLW >= COLS)
- ROWW, 5, row index width (2^ROWW >= ROWS)
- FIFO_DEPTH, 8, input byte FIFO depth (power of 2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- din  in  8  input byte
- dinv  in  1  one-cycle strobe; din valid
- wr_en  out  1  text-RAM write strobe
- wr_row  out  ROWW  physical RAM row of write
- wr_col  out  COLW  column of write
- wr_data  out  8  character code written
- scroll_top  out  ROWW  physical row displayed as top line
- cursor_row  out  ROWW  logical cursor row (0 = top)
- cursor_col  out  COLW  cursor column
- busy  out  1  FIFO non-empty or clear in progress
- error  out  1  one-cycle pulse: byte lost to FIFO overflow

Behaviour:
- Reset: clk and resetn as above; reset is asynchronous and active-low. All outputs 0, state IDLE, FIFO empty, stored CSI parameter 0.
- Input and latency:
  - din is pushed into the FIFO when dinv=1.
  - If dinv=1 while the FIFO is full, the byte is dropped and error=1 on the next cycle. The FIFO is unchanged.
  - In IDLE/ESC/CSI, the head byte is popped when the FIFO is non-empty and is decoded in the pop cycle.
  - Resulting write outputs and cursor updates are registered. With an idle, empty FIFO, din at cycle t gives wr_en at t+2.
- Address mapping: physical row = (scroll_top + logical row) mod ROWS. Wrap is explicit: no binary overflow past ROWS-1.
- Bytes decoded in IDLE:
  - 0x20-0x7E: write at cursor. If col < COLS-1, col+1. Otherwise col=0 and perform LF.
  - 0x0D CR: col=0.
  - 0x0A LF: if row < ROWS-1, row+1. Otherwise scroll: scroll_top = (scroll_top+1) mod ROWS, row stays ROWS-1, then enter CLRLINE on the new bottom physical row.
  - 0x08 BS: if col > 0, col-1; at col 0, no change.
  - 0x09 TAB: col = min((col | 7) + 1, COLS-1).
  - 0x1B: go to ESC.
  - All other bytes: ignored.
- ESC state:
  - '[' goes to CSI and clears the parameter.
  - Any other byte is discarded and returns to IDLE.
- CSI state:
  - '0'-'9': parameter = that digit (last digit wins); stay in CSI.
  - 'H': cursor to (0,0); return to IDLE.
  - 'J' with parameter 2: enter CLRSCR.
  - 'J' with any other parameter: ignored; return to IDLE.
  - 'K': enter CLRLINE from the cursor column to COLS-1 on the cursor row. Cursor is unchanged.
  - Any other byte: return to IDLE.
- CLRLINE:
  - One write of 0x20 per cycle, columns ascending, last at COLS-1, then IDLE.
  - A scroll-triggered clear runs from column 0.
- CLRSCR:
  - scroll_top=0 and cursor=(0,0) on entry.
  - Writes 0x20 to every cell, row-major, one per cycle: ROWS*COLS cycles. Then IDLE.
- No FIFO pops occur during CLRLINE/CLRSCR. Pushes continue, and overflow rules apply.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push is accepted.
- Assertion of resetn mid-clear aborts immediately. RAM contents are not restored.

Test Plan:
- Reset, then "A","B" → wr_en at (0,0) 0x41, then (0,1) 0x42; cursor_col=2; error=0.
- Cursor (5,79), byte 0x5A → write (5,79); cursor becomes (6,0).
- Cursor row 29 with scroll_top=0, byte 0x0A → scroll_top=1; cursor_row=29; 80 writes of 0x20 to physical row 0, columns 0..79; busy high throughout.
- Bytes 1B 5B 32 4A → scroll_top=0; cursor (0,0); 2400 space writes ending at (29,79); then busy=0.
- During ESC[2J, push 9 bytes → FIFO_DEPTH=8 accepts 8; error pulses once; the remaining 8 bytes are processed after the clear completes.
- Cursor col 3, bytes 09 08 1B 5B 4B → col 8, then col 7; 73 space writes at columns 7..79; cursor unchanged.
